// File: rtl/sram_1rw_pkg.sv
// Shared types and default geometry for the 1rw SRAM request controller.
// Defaults match the 15x4096 macro.
package sram_1rw_pkg;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  localparam int unsigned DEF_BITS       = 15;
  localparam int unsigned DEF_WORD_DEPTH = 4096;
  localparam int unsigned DEF_ADDR_WIDTH = 12;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cntWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_1rw_req_ctrl_fifo.sv
// Small synchronous response FIFO with an occupancy count.
// The head is read from registered storage, so nothing combinational reaches rdata_o.
module sram_rsp_fifo
  import sram_1rw_pkg::*;
#(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [cntWidth(DEPTH)-1:0] count_o
);

  localparam int unsigned CW = cntWidth(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop, full;

  function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= incPtr(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= incPtr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Initiator-side controller for a single-port 1rw SRAM macro: request stream in,
// macro pins out, read data back on a response stream, optional zero-fill after reset.
module sram_1rw_req_ctrl
  import sram_1rw_pkg::*;
#(
  parameter int unsigned BITS       = DEF_BITS,
  parameter int unsigned WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RSP_DEPTH  = 3,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BITS-1:0]       req_wmask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [BITS-1:0]       rsp_rdata,
  output logic                  init_done,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_w_mask,
  input  logic [BITS-1:0]       sram_rd
);

  localparam int unsigned CW = cntWidth(RSP_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic                  init_done_q;
  logic                  rd_inflight_q;
  logic                  rd_oor_q;

  logic [CW-1:0]         fifo_count;
  logic                  fire, in_range;
  logic [BITS-1:0]       push_data;

  // Credit counts both queued responses and the read whose data arrives next cycle.
  assign req_ready = !reset && (state_q == S_RUN) &&
                     (({1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight_q}) < (CW + 1)'(RSP_DEPTH));
  assign fire      = req_valid && req_ready;
  assign in_range  = ({1'b0, req_addr} < DEPTH_W);
  assign init_done = init_done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= INIT_EN ? S_INIT : S_RUN;
      init_cnt_q    <= '0;
      init_done_q   <= !INIT_EN;
      rd_inflight_q <= 1'b0;
      rd_oor_q      <= 1'b0;
    end else begin
      rd_inflight_q <= fire && !req_we;
      rd_oor_q      <= !in_range;
      if (state_q == S_INIT) begin
        if (init_cnt_q == LAST_ADDR) begin
          state_q     <= S_RUN;
          init_done_q <= 1'b1;
          init_cnt_q  <= '0;
        end else begin
          init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Macro pins are forced to zero whenever ce is low so the macro never sees X.
  always_comb begin
    sram_ce     = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wd     = '0;
    sram_w_mask = '0;
    if (reset) begin
      sram_ce = 1'b0;
    end else if (state_q == S_INIT) begin
      sram_ce     = 1'b1;
      sram_we     = 1'b1;
      sram_addr   = init_cnt_q;
      sram_w_mask = '1;
    end else if (fire && in_range) begin
      sram_ce   = 1'b1;
      sram_we   = req_we;
      sram_addr = req_addr;
      if (req_we) begin
        sram_wd     = req_wdata;
        sram_w_mask = req_wmask;
      end
    end
  end

  assign push_data = rd_oor_q ? '0 : sram_rd;

  sram_rsp_fifo #(
    .WIDTH (BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_inflight_q),
    .wdata_i (push_data),
    .pop_i   (rsp_ready),
    .valid_o (rsp_valid),
    .rdata_o (rsp_rdata),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Directed bench: two controllers (4096 words with zero-fill, 3000 words without)
// each driving a behavioural 15-bit 1rw macro model.
module tb_sram_1rw_req_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [1:0]  reqValid, reqReady, reqWe, rspValid, rspReady, initDone, sramCe, sramWe;
  logic [11:0] reqAddr [2];
  logic [11:0] sramAddr [2];
  logic [14:0] reqWdata [2];
  logic [14:0] reqWmask [2];
  logic [14:0] rspRdata [2];
  logic [14:0] sramWd [2];
  logic [14:0] sramMask [2];
  logic [14:0] sramRd [2];
  logic [14:0] mem [2][4096];

  int totalCnt = 0;
  int badCnt   = 0;
  int xErrs    = 0;

  logic        lastCe, lastWe;
  logic [11:0] lastAddr;
  logic [14:0] lastWd, lastMask;

  sram_1rw_req_ctrl #(
    .BITS(15), .WORD_DEPTH(4096), .ADDR_WIDTH(12), .RSP_DEPTH(3), .INIT_EN(1'b1)
  ) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_wmask(reqWmask[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]), .rsp_rdata(rspRdata[0]),
    .init_done(initDone[0]),
    .sram_ce(sramCe[0]), .sram_we(sramWe[0]), .sram_addr(sramAddr[0]),
    .sram_wd(sramWd[0]), .sram_w_mask(sramMask[0]), .sram_rd(sramRd[0])
  );

  sram_1rw_req_ctrl #(
    .BITS(15), .WORD_DEPTH(3000), .ADDR_WIDTH(12), .RSP_DEPTH(3), .INIT_EN(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_wmask(reqWmask[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]), .rsp_rdata(rspRdata[1]),
    .init_done(initDone[1]),
    .sram_ce(sramCe[1]), .sram_we(sramWe[1]), .sram_addr(sramAddr[1]),
    .sram_wd(sramWd[1]), .sram_w_mask(sramMask[1]), .sram_rd(sramRd[1])
  );

  // Macro model: masked write on ce&we, registered read data on ce&!we.
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[0][i] = 15'h5555;
      mem[1][i] = 15'h1234;
    end
    sramRd[0] = '0;
    sramRd[1] = '0;
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        if (sramCe[k]) begin
          if (sramWe[k])
            mem[k][sramAddr[k]] = (mem[k][sramAddr[k]] & ~sramMask[k]) | (sramWd[k] & sramMask[k]);
          else
            sramRd[k] <= mem[k][sramAddr[k]];
        end
      end
    end
  end

  always @(negedge clk) begin
    if ($isunknown({sramCe, sramWe, sramAddr[0], sramAddr[1], sramWd[0], sramWd[1],
                    sramMask[0], sramMask[1]}))
      xErrs++;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Holds a request until it fires, records the macro pins seen in the fire cycle.
  task automatic applyStimulus(input int sel, input logic we, input logic [11:0] addr,
                               input logic [14:0] wd, input logic [14:0] wm);
    int n;
    n = 0;
    reqValid[sel] = 1'b1;
    reqWe[sel]    = we;
    reqAddr[sel]  = addr;
    reqWdata[sel] = wd;
    reqWmask[sel] = wm;
    #1;
    while (!reqReady[sel] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!reqReady[sel]) checkOutput("reqTimeout", {31'b0, reqReady[sel]}, 32'd1);
    lastCe   = sramCe[sel];
    lastWe   = sramWe[sel];
    lastAddr = sramAddr[sel];
    lastWd   = sramWd[sel];
    lastMask = sramMask[sel];
    @(negedge clk);
    reqValid[sel] = 1'b0;
  endtask

  task automatic readCheck(input int sel, input logic [11:0] addr, input logic [14:0] exp,
                           input string tag);
    applyStimulus(sel, 1'b0, addr, 15'h0, 15'h0);
    checkOutput({tag, "_lat1"}, {31'b0, rspValid[sel]}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'b0, rspValid[sel]}, 32'd1);
    checkOutput({tag, "_data"}, {17'b0, rspRdata[sel]}, {17'b0, exp});
  endtask

  // Called in the first cycle after reset release; walks all 4096 zero-fill writes.
  task automatic checkInit(input string tag);
    int errs, rspSeen;
    errs = 0;
    rspSeen = 0;
    for (int i = 0; i < 4096; i++) begin
      if (!(sramCe[0] && sramWe[0] && sramAddr[0] == 12'(i) && sramWd[0] == 15'h0 &&
            sramMask[0] == 15'h7FFF && !initDone[0] && !reqReady[0]))
        errs++;
      if (rspValid[0]) rspSeen++;
      @(negedge clk);
    end
    checkOutput({tag, "_writes"}, errs, 0);
    checkOutput({tag, "_rsp"}, rspSeen, 0);
    checkOutput({tag, "_done"}, {31'b0, initDone[0]}, 32'd1);
    checkOutput({tag, "_ceIdle"}, {31'b0, sramCe[0]}, 32'd0);
  endtask

  initial begin
    int fired, got, cycles, errs;
    logic [14:0] rsps[$];

    reset    = 1'b1;
    reqValid = '0;
    reqWe    = '0;
    rspReady = 2'b11;
    for (int k = 0; k < 2; k++) begin
      reqAddr[k]  = '0;
      reqWdata[k] = '0;
      reqWmask[k] = '0;
    end
    repeat (3) @(negedge clk);

    checkOutput("rstCe0", {31'b0, sramCe[0]}, 32'd0);
    checkOutput("rstReady0", {31'b0, reqReady[0]}, 32'd0);
    checkOutput("rstRspV0", {31'b0, rspValid[0]}, 32'd0);
    checkOutput("rstDone0", {31'b0, initDone[0]}, 32'd0);
    checkOutput("rstDone1", {31'b0, initDone[1]}, 32'd1);
    checkOutput("rstReady1", {31'b0, reqReady[1]}, 32'd0);

    reset = 1'b0;
    #1;
    checkOutput("runReady1", {31'b0, reqReady[1]}, 32'd1);
    checkInit("init1");

    $display("[TB] read after zero-fill");
    readCheck(0, 12'hABC, 15'h0, "rdInit");

    $display("[TB] write then read next cycle");
    applyStimulus(0, 1'b1, 12'd5, 15'h7FFF, 15'h7FFF);
    checkOutput("wrCe", {31'b0, lastCe}, 32'd1);
    checkOutput("wrWe", {31'b0, lastWe}, 32'd1);
    checkOutput("wrAddr", {20'b0, lastAddr}, 32'd5);
    checkOutput("wrWd", {17'b0, lastWd}, 32'h7FFF);
    readCheck(0, 12'd5, 15'h7FFF, "rdAfterWr");
    checkOutput("rdCe", {31'b0, lastCe}, 32'd1);
    checkOutput("rdWe", {31'b0, lastWe}, 32'd0);
    checkOutput("rdWdZero", {17'b0, lastWd}, 32'd0);
    checkOutput("rdMaskZero", {17'b0, lastMask}, 32'd0);

    $display("[TB] partial mask");
    applyStimulus(0, 1'b1, 12'd9, 15'h7FFF, 15'h7FFF);
    applyStimulus(0, 1'b1, 12'd9, 15'h0000, 15'h00FF);
    readCheck(0, 12'd9, 15'h7F00, "partial");

    $display("[TB] back-pressure and ordering");
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 12'(20 + i), 15'(256 + i), 15'h7FFF);
    rspReady[0] = 1'b0;
    reqWe[0]    = 1'b0;
    fired = 0;
    for (int c = 0; c < 6; c++) begin
      reqValid[0] = (fired < 5);
      reqAddr[0]  = 12'(20 + fired);
      #1;
      if (reqValid[0] && reqReady[0]) fired++;
      @(negedge clk);
    end
    #1;
    checkOutput("stallFires", fired, 3);
    checkOutput("stallReady", {31'b0, reqReady[0]}, 32'd0);
    checkOutput("stallValid", {31'b0, rspValid[0]}, 32'd1);
    checkOutput("stallHead", {17'b0, rspRdata[0]}, 32'h100);
    @(negedge clk);
    checkOutput("stallHold", {17'b0, rspRdata[0]}, 32'h100);

    rspReady[0] = 1'b1;
    for (int c = 0; c < 30 && rsps.size() < 5; c++) begin
      reqValid[0] = (fired < 5);
      reqAddr[0]  = 12'(20 + fired);
      #1;
      if (reqValid[0] && reqReady[0]) fired++;
      if (rspValid[0]) rsps.push_back(rspRdata[0]);
      @(negedge clk);
    end
    reqValid[0] = 1'b0;
    checkOutput("drainCount", rsps.size(), 5);
    errs = 0;
    foreach (rsps[i]) if (rsps[i] != 15'(256 + i)) errs++;
    checkOutput("drainOrder", errs, 0);

    fired = 0;
    got = 0;
    cycles = 0;
    errs = 0;
    while (got < 100 && cycles < 400) begin
      reqValid[0] = (fired < 100);
      reqAddr[0]  = 12'(20 + fired % 5);
      #1;
      if (reqValid[0] && reqReady[0]) fired++;
      if (rspValid[0]) begin
        if (rspRdata[0] != 15'(256 + got % 5)) errs++;
        got++;
      end
      cycles++;
      @(negedge clk);
    end
    reqValid[0] = 1'b0;
    checkOutput("b2bCount", got, 100);
    checkOutput("b2bCycles", cycles, 102);
    checkOutput("b2bData", errs, 0);

    $display("[TB] reset with queued reads");
    rspReady[0] = 1'b0;
    applyStimulus(0, 1'b0, 12'd20, 15'h0, 15'h0);
    applyStimulus(0, 1'b0, 12'd21, 15'h0, 15'h0);
    @(negedge clk);
    checkOutput("preRstValid", {31'b0, rspValid[0]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstFlushV", {31'b0, rspValid[0]}, 32'd0);
    checkOutput("rstFlushReady", {31'b0, reqReady[0]}, 32'd0);
    checkOutput("rstFlushDone", {31'b0, initDone[0]}, 32'd0);
    checkOutput("rstCeGated", {31'b0, sramCe[0]}, 32'd0);
    rspReady[0] = 1'b1;
    reset = 1'b0;
    #1;
    checkInit("init2");
    readCheck(0, 12'd5, 15'h0, "rdReinit");

    $display("[TB] out-of-range on 3000-word instance");
    readCheck(1, 12'd100, 15'h1234, "inRange");
    applyStimulus(1, 1'b1, 12'd2999, 15'h2AAA, 15'h7FFF);
    checkOutput("lastWordCe", {31'b0, lastCe}, 32'd1);
    readCheck(1, 12'd2999, 15'h2AAA, "lastWord");
    applyStimulus(1, 1'b1, 12'd3500, 15'h7FFF, 15'h7FFF);
    checkOutput("oorWrCe", {31'b0, lastCe}, 32'd0);
    readCheck(1, 12'd3500, 15'h0, "oorRead");
    checkOutput("oorRdCe", {31'b0, lastCe}, 32'd0);
    readCheck(1, 12'd3000, 15'h0, "oorBoundary");
    checkOutput("oorWrDropped", {17'b0, mem[1][3500]}, 32'h1234);

    checkOutput("noX", xErrs, 0);
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
